// File: rtl/iram_mon_ctrl.sv
// Monitor-side controller for the instruction RAM: starts/halts the CPU and
// steals the IRAM ports for single-word reads and writes while the CPU is halted.
module iram_mon_ctrl #(
  parameter int DRAIN_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mon_run_req,
  input  logic [29:0] mon_start_adr,
  input  logic        mon_stop_req,
  input  logic        mon_rd_req,
  input  logic [9:0]  mon_rd_adr,
  input  logic        mon_wr_req,
  input  logic [9:0]  mon_wr_adr,
  input  logic [31:0] mon_wr_data,
  output logic [31:0] mon_rd_data,
  output logic        mon_rd_vld,
  output logic        mon_busy,
  output logic        mon_err,
  output logic [9:0]  i_ram_radr,
  output logic        i_read_sel,
  input  logic [31:0] i_ram_rdata,
  output logic [9:0]  i_ram_wadr,
  output logic [31:0] i_ram_wdata,
  output logic        i_ram_wen,
  output logic        cpu_start,
  output logic [29:0] start_adr,
  output logic        cpu_halt,
  output logic        rst_pipe,
  output logic        cpu_running
);

  typedef enum logic [2:0] {
    HALT   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    RD_ADR = 3'd3,
    RD_DAT = 3'd4,
    WR     = 3'd5
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  drain_cnt, drain_cnt_nxt;
  logic [9:0]  rd_adr_q, wr_adr_q;
  logic [31:0] wr_data_q, rd_data_q;
  logic [29:0] start_adr_q;
  logic        rd_vld_q, err_q, start_q, pipe_q;
  logic        ld_rd, ld_wr, ld_start, cap_rd;
  logic        rd_vld_nxt, err_nxt, start_nxt, pipe_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HALT;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Only HALT accepts monitor requests; every other state either runs the CPU
  // or is busy with a sequence, so requests there are dropped or flagged.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    ld_rd         = 1'b0;
    ld_wr         = 1'b0;
    ld_start      = 1'b0;
    cap_rd        = 1'b0;
    rd_vld_nxt    = 1'b0;
    err_nxt       = 1'b0;
    start_nxt     = 1'b0;
    pipe_nxt      = 1'b0;
    case (state)
      HALT: begin
        if (mon_wr_req) begin
          state_nxt = WR;
          ld_wr     = 1'b1;
        end else if (mon_rd_req) begin
          state_nxt = RD_ADR;
          ld_rd     = 1'b1;
        end else if (mon_run_req) begin
          state_nxt = RUN;
          ld_start  = 1'b1;
          start_nxt = 1'b1;
        end
      end
      RUN: begin
        if (mon_stop_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
        if (mon_rd_req || mon_wr_req) begin
          err_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) begin
          state_nxt = HALT;
          pipe_nxt  = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt - 4'd1;
        end
      end
      RD_ADR: begin
        state_nxt = RD_DAT;
      end
      RD_DAT: begin
        state_nxt  = HALT;
        cap_rd     = 1'b1;
        rd_vld_nxt = 1'b1;
      end
      WR: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_adr_q    <= 10'd0;
      wr_adr_q    <= 10'd0;
      wr_data_q   <= 32'd0;
      start_adr_q <= 30'd0;
      rd_data_q   <= 32'd0;
      rd_vld_q    <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      pipe_q      <= 1'b0;
    end else begin
      if (ld_rd) begin
        rd_adr_q <= mon_rd_adr;
      end
      if (ld_wr) begin
        wr_adr_q  <= mon_wr_adr;
        wr_data_q <= mon_wr_data;
      end
      if (ld_start) begin
        start_adr_q <= mon_start_adr;
      end
      if (cap_rd) begin
        rd_data_q <= i_ram_rdata;
      end
      rd_vld_q <= rd_vld_nxt;
      err_q    <= err_nxt;
      start_q  <= start_nxt;
      pipe_q   <= pipe_nxt;
    end
  end

  assign mon_rd_data = rd_data_q;
  assign mon_rd_vld  = rd_vld_q;
  assign mon_err     = err_q;
  assign mon_busy    = (state == DRAIN) || (state == RD_ADR) ||
                       (state == RD_DAT) || (state == WR);
  assign i_read_sel  = (state == RD_ADR) || (state == RD_DAT);
  assign i_ram_radr  = rd_adr_q;
  assign i_ram_wen   = (state == WR);
  assign i_ram_wadr  = wr_adr_q;
  assign i_ram_wdata = wr_data_q;
  assign cpu_start   = start_q;
  assign start_adr   = start_adr_q;
  assign cpu_halt    = (state != RUN);
  assign cpu_running = (state == RUN);
  assign rst_pipe    = pipe_q;

endmodule

// File: tb/tb_iram_mon_ctrl.sv
// Scoreboard bench for iram_mon_ctrl: directed monitor requests queue their
// expected pulse events, a negedge monitor matches every pulse the DUT emits.
module tb_iram_mon_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mon_run_req = 1'b0;
  logic [29:0] mon_start_adr = '0;
  logic        mon_stop_req = 1'b0;
  logic        mon_rd_req = 1'b0;
  logic [9:0]  mon_rd_adr = '0;
  logic        mon_wr_req = 1'b0;
  logic [9:0]  mon_wr_adr = '0;
  logic [31:0] mon_wr_data = '0;
  logic [31:0] mon_rd_data;
  logic        mon_rd_vld, mon_busy, mon_err;
  logic [9:0]  i_ram_radr, i_ram_wadr;
  logic        i_read_sel, i_ram_wen;
  logic [31:0] i_ram_rdata = '0;
  logic [31:0] i_ram_wdata;
  logic        cpu_start, cpu_halt, rst_pipe, cpu_running;
  logic [29:0] start_adr;

  iram_mon_ctrl #(.DRAIN_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mon_run_req(mon_run_req), .mon_start_adr(mon_start_adr),
    .mon_stop_req(mon_stop_req),
    .mon_rd_req(mon_rd_req), .mon_rd_adr(mon_rd_adr),
    .mon_wr_req(mon_wr_req), .mon_wr_adr(mon_wr_adr), .mon_wr_data(mon_wr_data),
    .mon_rd_data(mon_rd_data), .mon_rd_vld(mon_rd_vld),
    .mon_busy(mon_busy), .mon_err(mon_err),
    .i_ram_radr(i_ram_radr), .i_read_sel(i_read_sel), .i_ram_rdata(i_ram_rdata),
    .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen),
    .cpu_start(cpu_start), .start_adr(start_adr), .cpu_halt(cpu_halt),
    .rst_pipe(rst_pipe), .cpu_running(cpu_running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple synchronous-read IRAM model: data appears one cycle after the address.
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (i_ram_wen) mem[i_ram_wadr] <= i_ram_wdata;
    i_ram_rdata <= mem[i_ram_radr];
  end

  typedef enum {EV_NONE, EV_WEN, EV_START, EV_PIPE, EV_ERR, EV_RD} ev_e;
  typedef struct {
    ev_e         kind;
    logic [63:0] val;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score_event(input ev_e k, input logic [63:0] v);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_%s actual val=%0h cyc=%0d required no event", k.name(), v, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val !== v || e.cyc != cyc) begin
        errors++;
        $display("[TB] FAIL event_%s actual kind=%s val=%0h cyc=%0d required kind=%s val=%0h cyc=%0d",
                 e.kind.name(), k.name(), v, cyc, e.kind.name(), e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (i_ram_wen)   score_event(EV_WEN,   {22'b0, i_ram_wadr, i_ram_wdata});
    if (cpu_start)   score_event(EV_START, {34'b0, start_adr});
    if (rst_pipe)    score_event(EV_PIPE,  64'h0);
    if (mon_err)     score_event(EV_ERR,   64'h0);
    if (mon_rd_vld)  score_event(EV_RD,    {32'b0, mon_rd_data});
  end

  // Drives one request cycle and queues the single pulse it should cause, if any.
  // Returns at the negedge of the first cycle after the request was sampled.
  task automatic applyStimulus(input logic run, input logic stop, input logic rd, input logic wr,
                               input logic [29:0] sadr, input logic [9:0] adr,
                               input logic [31:0] data,
                               input ev_e k, input logic [63:0] v, input int lat);
    exp_t e;
    @(negedge clk);
    mon_run_req   = run;
    mon_stop_req  = stop;
    mon_rd_req    = rd;
    mon_wr_req    = wr;
    mon_start_adr = sadr;
    mon_rd_adr    = adr;
    mon_wr_adr    = adr;
    mon_wr_data   = data;
    if (k != EV_NONE) begin
      e.kind = k;
      e.val  = v;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    mon_run_req  = 1'b0;
    mon_stop_req = 1'b0;
    mon_rd_req   = 1'b0;
    mon_wr_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(3);
    checkOutput("rst_cpu_halt", cpu_halt, 1);
    checkOutput("rst_running", cpu_running, 0);
    checkOutput("rst_busy", mon_busy, 0);
    checkOutput("rst_read_sel", i_read_sel, 0);
    checkOutput("rst_wen", i_ram_wen, 0);
    checkOutput("rst_rd_data", mon_rd_data, 0);
    checkOutput("rst_start_adr", start_adr, 0);
    checkOutput("rst_pulses", {cpu_start, rst_pipe, mon_rd_vld, mon_err}, 0);
    rst_n = 1'b1;
    idle(2);

    // write 0x005 = DEADBEEF, then read it back
    applyStimulus(0, 0, 0, 1, '0, 10'h005, 32'hDEADBEEF, EV_WEN, {22'b0, 10'h005, 32'hDEADBEEF}, 1);
    checkOutput("wr_busy", mon_busy, 1);
    checkOutput("wr_halt", cpu_halt, 1);
    idle(1);
    checkOutput("wr_done_busy", mon_busy, 0);
    applyStimulus(0, 0, 1, 0, '0, 10'h005, '0, EV_RD, {32'b0, 32'hDEADBEEF}, 3);
    checkOutput("rdadr_sel", i_read_sel, 1);
    checkOutput("rdadr_radr", i_ram_radr, 10'h005);
    checkOutput("rdadr_busy", mon_busy, 1);
    idle(1);
    checkOutput("rddat_sel", i_read_sel, 1);
    idle(1);
    checkOutput("rd_done_sel", i_read_sel, 0);
    checkOutput("rd_done_busy", mon_busy, 0);
    checkOutput("rd_data_hold", mon_rd_data, 32'hDEADBEEF);

    // write and read together: write wins, no read valid
    applyStimulus(0, 0, 1, 1, '0, 10'h3FF, 32'h12345678, EV_WEN, {22'b0, 10'h3FF, 32'h12345678}, 1);
    checkOutput("wrrd_sel", i_read_sel, 0);
    idle(3);
    applyStimulus(0, 0, 1, 0, '0, 10'h3FF, '0, EV_RD, {32'b0, 32'h12345678}, 3);
    idle(3);

    // stop in HALT is ignored
    applyStimulus(0, 1, 0, 0, '0, '0, '0, EV_NONE, 64'h0, 0);
    checkOutput("stop_halt_busy", mon_busy, 0);
    checkOutput("stop_halt_halt", cpu_halt, 1);

    // run at byte address 0x10
    applyStimulus(1, 0, 0, 0, 30'h4, '0, '0, EV_START, 64'h4, 1);
    checkOutput("run_running", cpu_running, 1);
    checkOutput("run_halt", cpu_halt, 0);
    checkOutput("run_start_adr", start_adr, 30'h4);
    applyStimulus(1, 0, 0, 0, 30'h7, '0, '0, EV_NONE, 64'h0, 0);
    checkOutput("run_again_adr", start_adr, 30'h4);

    // rd / wr while running are rejected with an error pulse
    applyStimulus(0, 0, 1, 0, '0, 10'h005, '0, EV_ERR, 64'h0, 1);
    checkOutput("rd_run_sel", i_read_sel, 0);
    checkOutput("rd_run_state", cpu_running, 1);
    idle(1);
    checkOutput("rd_run_sel2", i_read_sel, 0);
    applyStimulus(0, 0, 0, 1, '0, 10'h005, 32'hFFFFFFFF, EV_ERR, 64'h0, 1);
    checkOutput("wr_run_state", cpu_running, 1);

    // stop: rst_pipe four cycles after DRAIN entry; requests in DRAIN ignored
    applyStimulus(0, 1, 0, 0, '0, '0, '0, EV_PIPE, 64'h0, 5);
    checkOutput("drain_halt", cpu_halt, 1);
    checkOutput("drain_busy", mon_busy, 1);
    checkOutput("drain_running", cpu_running, 0);
    applyStimulus(1, 1, 1, 0, 30'h9, 10'h005, '0, EV_NONE, 64'h0, 0);
    checkOutput("drain_busy2", mon_busy, 1);
    idle(2);
    checkOutput("drained_busy", mon_busy, 0);
    checkOutput("drained_halt", cpu_halt, 1);
    checkOutput("drained_adr", start_adr, 30'h4);

    // run with max address, then run+stop together: stop taken
    applyStimulus(1, 0, 0, 0, 30'h3FFFFFFF, '0, '0, EV_START, 64'h3FFFFFFF, 1);
    checkOutput("run_max_adr", start_adr, 30'h3FFFFFFF);
    applyStimulus(1, 1, 0, 0, 30'h1, '0, '0, EV_PIPE, 64'h0, 5);
    checkOutput("runstop_busy", mon_busy, 1);
    checkOutput("runstop_running", cpu_running, 0);
    idle(5);

    // reset asserted during RD_DAT aborts the read
    applyStimulus(0, 0, 1, 0, '0, 10'h3FF, '0, EV_NONE, 64'h0, 0);
    checkOutput("abort_rdadr_sel", i_read_sel, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sel", i_read_sel, 0);
    checkOutput("abort_busy", mon_busy, 0);
    checkOutput("abort_rd_data", mon_rd_data, 0);
    checkOutput("abort_halt", cpu_halt, 1);
    checkOutput("abort_start_adr", start_adr, 0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    checkOutput("abort_rd_data2", mon_rd_data, 0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iram_mon_ctrl.md
IRAM_MON_CTRL -- requirements
Module: iram_mon_ctrl

Interface
REQ-001 Parameter DRAIN_CYC, default 4: number of cycles the pipeline drains between a stop request and the HALT state (legal range 1..15).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 mon_run_req  in  1  one-cycle pulse from the monitor: start the CPU at mon_start_adr.
REQ-005 mon_start_adr  in  30 [31:2]  start address for the CPU.
REQ-006 mon_stop_req  in  1  one-cycle pulse from the monitor: halt the CPU.
REQ-007 mon_rd_req / mon_rd_adr  in  1 / 10 [11:2]  request to read an IRAM word, and its address.
REQ-008 mon_wr_req / mon_wr_adr / mon_wr_data  in  1 / 10 [11:2] / 32  request to write an IRAM word, with address and data.
REQ-009 mon_rd_data  out  32  last word read back from IRAM.
REQ-010 mon_rd_vld  out  1  one-cycle pulse: mon_rd_data has been updated.
REQ-011 mon_busy  out  1  a request is in progress; new requests are ignored.
REQ-012 mon_err  out  1  one-cycle pulse: a rd/wr request arrived outside HALT and was rejected.
REQ-013 i_ram_radr / i_read_sel  out  10 / 1  monitor read address into the IRAM, and the read-port steal select.
REQ-014 i_ram_rdata  in  32  IRAM read data; valid one cycle after the read address is presented.
REQ-015 i_ram_wadr / i_ram_wdata / i_ram_wen  out  10 / 32 / 1  IRAM write port.
REQ-016 cpu_start / start_adr  out  1 / 30  CPU start pulse and the registered start address.
REQ-017 cpu_halt  out  1  level signal that freezes instruction fetch (stall source).
REQ-018 rst_pipe  out  1  one-cycle pulse that flushes the pipeline registers.
REQ-019 cpu_running  out  1  high in the RUN state only.

Function
REQ-020 The FSM SHALL have the states HALT, RUN, DRAIN, RD_ADR, RD_DAT, WR, with reset state HALT.
REQ-021 Request priority in HALT SHALL be: write > read > run; requests that lose in the same cycle are dropped.
REQ-022 HALT + mon_wr_req SHALL move to WR: in the next cycle i_ram_wen=1 for exactly one cycle, carrying the registered address and data; then the FSM returns to HALT.
REQ-023 HALT + mon_rd_req at cycle T SHALL give: RD_ADR at T+1 (i_read_sel=1, i_ram_radr=registered address); RD_DAT at T+2 (i_read_sel=1, i_ram_rdata captured); mon_rd_data updated and mon_rd_vld=1 at T+3; back in HALT at T+3.
REQ-024 i_read_sel SHALL be 1 only in RD_ADR and RD_DAT.
REQ-025 HALT + mon_run_req SHALL give, next cycle: cpu_start=1 for one cycle, start_adr=mon_start_adr captured at the request, and the RUN state.
REQ-026 RUN + mon_stop_req SHALL move to DRAIN with cpu_halt=1; a down-counter loaded with DRAIN_CYC-1 decrements each cycle; at 0 the FSM enters HALT with rst_pipe=1 for that first HALT cycle.
REQ-027 cpu_halt SHALL be 1 in DRAIN, HALT, RD_ADR, RD_DAT and WR, and 0 in RUN.
REQ-028 mon_busy SHALL be 1 in DRAIN, RD_ADR, RD_DAT and WR.
REQ-029 Requests arriving while mon_busy=1 SHALL be ignored with no error.
REQ-030 mon_rd_req or mon_wr_req in RUN SHALL pulse mon_err the next cycle and leave the state unchanged.
REQ-031 mon_run_req in RUN, mon_stop_req in HALT, and mon_stop_req/mon_run_req in DRAIN SHALL be ignored.
REQ-032 If mon_run_req and mon_stop_req are both high in RUN, the stop SHALL be taken.
REQ-033 Address fields SHALL pass through unchanged, with no wrap or arithmetic; the drain counter SHALL be 4 bits and saturate at 0.

Reset
REQ-034 While rst_n=0, the FSM SHALL be in HALT and all outputs SHALL be 0 except cpu_halt=1; mon_rd_data, start_adr and the drain counter SHALL be 0.
REQ-035 Reset asserted in any state, including mid-read or mid-drain, SHALL abort the operation with no i_ram_wen and no rd_vld pulse.

Verification
REQ-036 Write then read: wr 0x005=0xDEADBEEF, then rd 0x005 -> one i_ram_wen cycle, then mon_rd_vld at T+3 with mon_rd_data=0xDEADBEEF.
REQ-037 Run/stop: run with adr 0x00000010>>2 -> cpu_start for 1 cycle, start_adr=0x4; stop -> cpu_halt high, rst_pipe exactly 4 cycles after DRAIN entry (DRAIN_CYC=4).
REQ-038 rd_req while in RUN -> mon_err pulse, i_read_sel stays 0, FSM stays in RUN.
REQ-039 wr_req and rd_req in the same cycle in HALT -> only the write is performed, no mon_rd_vld.
REQ-040 rst_n asserted in RD_DAT -> HALT, mon_rd_vld never pulses, mon_rd_data=0.
REQ-041 run_req and stop_req in the same cycle in RUN -> DRAIN entered, no cpu_start.
